// File: rtl/mux4x1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4x1_rr_arbiter
//   Round-robin arbiter and sequencer for a shared 4x1 mux of W-bit inputs.
//   Four requesters (U, V, W_in, X) compete for the mux. One requester is
//   granted at a time. Its index drives the mux select, and the selected data
//   is registered onto Y with a Valid strobe. A grant is held for at most
//   MAX_HOLD consecutive cycles. It is released early when the holder drops
//   its request. On release, arbitration restarts from the index just after
//   the released holder, so the next grant follows with no idle cycle between.
//
// Parameters
//   W         data width of each mux input and of Y
//   MAX_HOLD  maximum consecutive cycles one grant is held (>= 1)
//
// Ports
//   Clock   in   1   system clock, rising edge
//   Reset   in   1   asynchronous active-high reset
//   Req     in   4   request lines: [0]=U, [1]=V, [2]=W_in, [3]=X
//   U       in   W   mux input 0
//   V       in   W   mux input 1
//   W_in    in   W   mux input 2
//   X       in   W   mux input 3
//   Sel     out  2   registered select = index of the granted requester
//   Grant   out  4   registered one-hot grant, 0000 when idle
//   Valid   out  1   Y holds data sampled from the granted input
//   Y       out  W   registered mux output
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// mux4x1_rr_arbiter_chk
//   Property checker for the arbiter's registered state.
//   Ports: clk/rst, and the registered grant, select, hold counter and valid.
// -----------------------------------------------------------------------------
module mux4x1_rr_arbiter_chk #(
    parameter int MAX_HOLD = 4,
    parameter int CW       = 3
) (
    input logic          clk,
    input logic          rst,
    input logic [3:0]    grant,
    input logic [1:0]    sel,
    input logic [CW-1:0] cnt,
    input logic          valid
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant));

    a_sel_matches_grant: assert property (@(posedge clk) disable iff (rst)
        (grant != 4'b0000) |-> grant[sel]);

    a_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
        cnt <= CNT_MAX);

    // Valid can only follow a cycle in which some requester held the mux.
    a_valid_after_grant: assert property (@(posedge clk) disable iff (rst)
        valid |-> ($past(grant) != 4'b0000));

endmodule

module mux4x1_rr_arbiter #(
    parameter int W        = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [3:0]   Req,
    input  logic [W-1:0] U,
    input  logic [W-1:0] V,
    input  logic [W-1:0] W_in,
    input  logic [W-1:0] X,
    output logic [1:0]   Sel,
    output logic [3:0]   Grant,
    output logic         Valid,
    output logic [W-1:0] Y
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_HOLD);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // First index with a request, scanning last+1, last+2, last+3, last+0.
    // The result is only used when at least one request is set.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    // Convert a requester index to its one-hot grant vector.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    logic [0:0]    state_r;
    logic [1:0]    sel_r;
    logic [3:0]    grant_r;
    logic          valid_r;
    logic [W-1:0]  y_r;
    logic [1:0]    last_r;
    logic [CW-1:0] cnt_r;

    logic          any_req_s;
    logic          holder_req_s;
    logic          release_s;
    logic [1:0]    last_eff_s;
    logic [1:0]    pick_s;
    logic [W-1:0]  mux_s;

    // Select the data of the current holder.
    always_comb begin
        mux_s = {W{1'b0}};
        case (sel_r)
            2'd0:    mux_s = U;
            2'd1:    mux_s = V;
            2'd2:    mux_s = W_in;
            2'd3:    mux_s = X;
            default: mux_s = {W{1'b0}};
        endcase
    end

    // Release detection and the round-robin pick.
    // The pick uses the released holder as the new "last", so the holder
    // only wins again when it is the sole requester.
    always_comb begin
        any_req_s    = |Req;
        holder_req_s = Req[sel_r];
        if (state_r == ST_GRANT) begin
            release_s = !holder_req_s || (cnt_r == CNT_MAX);
        end else begin
            release_s = 1'b0;
        end
        if (release_s) begin
            last_eff_s = sel_r;
        end else begin
            last_eff_s = last_r;
        end
        pick_s = rr_pick(Req, last_eff_s);
    end

    // Arbiter state, grant, select, hold counter and registered mux output.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            sel_r   <= 2'd0;
            grant_r <= 4'b0000;
            valid_r <= 1'b0;
            y_r     <= {W{1'b0}};
            last_r  <= 2'd3;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (any_req_s) begin
                        state_r <= ST_GRANT;
                        grant_r <= onehot4(pick_s);
                        sel_r   <= pick_s;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        grant_r <= 4'b0000;
                    end
                end
                ST_GRANT: begin
                    // Sample the holder's data only while it still requests.
                    valid_r <= holder_req_s;
                    if (holder_req_s) begin
                        y_r <= mux_s;
                    end else begin
                        y_r <= y_r;
                    end
                    if (release_s) begin
                        last_r <= sel_r;
                        if (any_req_s) begin
                            grant_r <= onehot4(pick_s);
                            sel_r   <= pick_s;
                            cnt_r   <= CNT_ONE;
                        end else begin
                            state_r <= ST_IDLE;
                            grant_r <= 4'b0000;
                            cnt_r   <= CNT_ZERO;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= 4'b0000;
                    valid_r <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign Sel   = sel_r;
    assign Grant = grant_r;
    assign Valid = valid_r;
    assign Y     = y_r;

    mux4x1_rr_arbiter_chk #(
        .MAX_HOLD (MAX_HOLD),
        .CW       (CW)
    ) u_chk (
        .clk   (Clock),
        .rst   (Reset),
        .grant (grant_r),
        .sel   (sel_r),
        .cnt   (cnt_r),
        .valid (valid_r)
    );

endmodule
